// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared types and fault rule for the data memory responder
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE    = 2'b00,
        MEM_HALF    = 2'b01,
        MEM_WORD    = 2'b10,
        MEM_ILLEGAL = 2'b11
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WAIT  = 2'b01,
        RESP  = 2'b10,
        FAULT = 2'b11
    } resp_state_t;

    localparam int LATENCY_MAX = 15;

    // An access faults when its size is illegal or its address is not naturally aligned
    function automatic logic access_fault(mem_size_t size, logic [1:0] offset);
        logic f;
        case (size)
            MEM_BYTE: f = 1'b0;
            MEM_HALF: f = offset[0];
            MEM_WORD: f = |offset;
            default:  f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - core-to-responder data port bundle
interface data_mem_responder_if #(
    parameter int WORD_SIZE = 32
);
    logic                 MemReq;
    logic                 MemWrite;
    logic [1:0]           MemSize;
    logic                 MemUnsigned;
    logic [WORD_SIZE-1:0] ALUResult;
    logic [WORD_SIZE-1:0] WriteData;
    logic [WORD_SIZE-1:0] MemData;
    logic                 MemReady;
    logic                 MemStall;
    logic                 MemFault;

    modport master (
        output MemReq, MemWrite, MemSize, MemUnsigned, ALUResult, WriteData,
        input  MemData, MemReady, MemStall, MemFault
    );

    modport slave (
        input  MemReq, MemWrite, MemSize, MemUnsigned, ALUResult, WriteData,
        output MemData, MemReady, MemStall, MemFault
    );
endinterface

// File: rtl/data_mem_responder_lane_align.sv
// rtl/data_mem_responder_lane_align.sv - little-endian byte lane steering for stores and loads
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  mem_size_t            size,
    input  logic [1:0]           offset,
    input  logic                 is_unsigned,
    input  logic [WORD_SIZE-1:0] wdata,
    input  logic [WORD_SIZE-1:0] rword,
    output logic [3:0]           byte_en,
    output logic [WORD_SIZE-1:0] wword,
    output logic [WORD_SIZE-1:0] rdata
);
    logic [WORD_SIZE-1:0] shifted;

    assign shifted = rword >> {offset, 3'b000};

    // Replicate store data across lanes so the byte enables alone pick the target lanes
    always_comb begin
        byte_en = 4'b0000;
        wword   = wdata;
        rdata   = shifted;
        case (size)
            MEM_BYTE: begin
                byte_en = 4'b0001 << offset;
                wword   = {(WORD_SIZE/8){wdata[7:0]}};
                rdata   = is_unsigned ? {{(WORD_SIZE-8){1'b0}}, shifted[7:0]}
                                      : {{(WORD_SIZE-8){shifted[7]}}, shifted[7:0]};
            end
            MEM_HALF: begin
                byte_en = offset[1] ? 4'b1100 : 4'b0011;
                wword   = {(WORD_SIZE/16){wdata[15:0]}};
                rdata   = is_unsigned ? {{(WORD_SIZE-16){1'b0}}, shifted[15:0]}
                                      : {{(WORD_SIZE-16){shifted[15]}}, shifted[15:0]};
            end
            MEM_WORD: begin
                byte_en = 4'b1111;
            end
            default: begin
                byte_en = 4'b0000;
            end
        endcase
    end
endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - latency-programmable data memory responder with fault reporting
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int DEPTH     = 1024,
    parameter int LATENCY   = 2
) (
    input  logic               clk,
    input  logic               reset,
    data_mem_responder_if.slave bus
);
    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

    resp_state_t          state;
    logic [3:0]           cnt;
    logic                 req_write;
    logic                 req_unsigned;
    mem_size_t            req_size;
    logic [1:0]           req_offset;
    logic [AW-1:0]        req_index;
    logic [WORD_SIZE-1:0] req_wdata;
    logic [WORD_SIZE-1:0] mem_data_q;
    logic [WORD_SIZE-1:0] ram [DEPTH];

    logic                 req_fault;
    logic [3:0]           byte_en;
    logic [WORD_SIZE-1:0] write_word;
    logic [WORD_SIZE-1:0] load_data;
    logic                 unused_addr_bits;

    // Upper address bits are ignored so the RAM aliases modulo 4*DEPTH bytes
    assign unused_addr_bits = ^bus.ALUResult[WORD_SIZE-1:AW+2];
    assign req_fault        = access_fault(mem_size_t'(bus.MemSize), bus.ALUResult[1:0]);

    mem_lane_align #(.WORD_SIZE(WORD_SIZE)) u_lane (
        .size        (req_size),
        .offset      (req_offset),
        .is_unsigned (req_unsigned),
        .wdata       (req_wdata),
        .rword       (ram[req_index]),
        .byte_en     (byte_en),
        .wword       (write_word),
        .rdata       (load_data)
    );

    // Request capture, latency count and response sequencing
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            mem_data_q   <= '0;
            req_write    <= 1'b0;
            req_unsigned <= 1'b0;
            req_size     <= MEM_BYTE;
            req_offset   <= 2'b00;
            req_index    <= '0;
            req_wdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.MemReq) begin
                        req_write    <= bus.MemWrite;
                        req_unsigned <= bus.MemUnsigned;
                        req_size     <= mem_size_t'(bus.MemSize);
                        req_offset   <= bus.ALUResult[1:0];
                        req_index    <= bus.ALUResult[AW+1:2];
                        req_wdata    <= bus.WriteData;
                        if (req_fault) begin
                            state <= FAULT;
                        end else if (LATENCY == 1) begin
                            state <= RESP;
                        end else begin
                            cnt   <= LAT_LOAD;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (!req_write) begin
                        mem_data_q <= load_data;
                    end
                    state <= IDLE;
                end
                FAULT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Store commit in the response cycle; a coincident reset suppresses it
    always_ff @(posedge clk) begin
        if (!reset && state == RESP && req_write) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    ram[req_index][8*i +: 8] <= write_word[8*i +: 8];
                end
            end
        end
    end

    assign bus.MemReady = !reset && (state == RESP || state == FAULT);
    assign bus.MemFault = !reset && (state == FAULT);
    assign bus.MemStall = !reset && ((state == IDLE && bus.MemReq) || state == WAIT);
    assign bus.MemData  = (state == RESP && !req_write) ? load_data : mem_data_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench with byte-level memory model
module tb_data_mem_responder;
    localparam int W     = 32;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    data_mem_responder_if #(.WORD_SIZE(W)) bus ();

    data_mem_responder #(.WORD_SIZE(W), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [7:0]  model_mem [4*DEPTH];
    int          acc_c = -100;
    int          rdy_c = -100;
    bit          exp_fault_v = 1'b0;
    bit          exp_is_load = 1'b0;
    logic [31:0] exp_load = '0;
    logic [31:0] hold_data = '0;
    logic [31:0] got_data;
    logic        got_fault;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            check("ready_during_reset", {31'd0, bus.MemReady}, 32'd0);
            hold_data = '0;
        end else begin
            check("stall", {31'd0, bus.MemStall}, {31'd0, (cyc >= acc_c && cyc < rdy_c)});
            check("ready", {31'd0, bus.MemReady}, {31'd0, (cyc == rdy_c)});
            check("fault", {31'd0, bus.MemFault}, {31'd0, (cyc == rdy_c && exp_fault_v)});
            if (cyc == rdy_c && exp_is_load && !exp_fault_v) begin
                check("load_data", bus.MemData, exp_load);
                hold_data = exp_load;
            end else begin
                check("held_data", bus.MemData, hold_data);
            end
        end
    end

    task automatic access(input bit wr, input logic [1:0] size, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input bit scramble, input bit abort);
        int          ba;
        int          nbytes;
        bit          fault;
        logic [31:0] v;
        @(posedge clk); #1;
        bus.MemReq      = 1'b1;
        bus.MemWrite    = wr;
        bus.MemSize     = size;
        bus.MemUnsigned = uns;
        bus.ALUResult   = addr;
        bus.WriteData   = wdata;
        ba     = int'(addr & 32'(4*DEPTH - 1));
        nbytes = 1 << size;
        fault  = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
        v = '0;
        if (!fault) begin
            for (int i = 0; i < nbytes; i++) v[8*i +: 8] = model_mem[ba + i];
            if (!uns && size == 2'b00 && v[7])  v[31:8]  = '1;
            if (!uns && size == 2'b01 && v[15]) v[31:16] = '1;
        end
        exp_load    = v;
        exp_is_load = !wr;
        exp_fault_v = fault;
        acc_c       = cyc;
        rdy_c       = cyc + (fault ? 1 : LAT);
        got_data    = 'x;
        got_fault   = 1'bx;
        @(posedge clk); #1;
        bus.MemReq = 1'b0;
        if (abort) begin
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            acc_c = -100;
            rdy_c = -100;
        end else begin
            while (cyc <= rdy_c) begin
                if (cyc == rdy_c) begin
                    got_data  = bus.MemData;
                    got_fault = bus.MemFault;
                end
                if (scramble) begin
                    bus.ALUResult   = $urandom;
                    bus.WriteData   = $urandom;
                    bus.MemSize     = 2'($urandom_range(0, 3));
                    bus.MemUnsigned = 1'($urandom_range(0, 1));
                    bus.MemWrite    = 1'($urandom_range(0, 1));
                end
                @(posedge clk); #1;
            end
            if (wr && !fault) begin
                for (int i = 0; i < nbytes; i++) model_mem[ba + i] = wdata[8*i +: 8];
            end
        end
    endtask

    initial begin
        bus.MemReq      = 1'b1;
        bus.MemWrite    = 1'b1;
        bus.MemSize     = 2'b10;
        bus.MemUnsigned = 1'b0;
        bus.ALUResult   = 32'h0000_0010;
        bus.WriteData   = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        bus.MemReq = 1'b0;
        reset      = 1'b0;

        access(1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF, 0, 0);
        access(0, 2'b10, 0, 32'h10, 32'h0, 0, 0);
        check("lit_word_load", got_data, 32'hDEAD_BEEF);
        check("lit_word_nofault", {31'd0, got_fault}, 32'd0);

        access(1, 2'b10, 0, 32'h10, 32'h0, 0, 0);
        access(1, 2'b00, 0, 32'h11, 32'h0000_0080, 0, 0);
        access(0, 2'b10, 0, 32'h10, 32'h0, 0, 0);
        check("lit_byte_merge", got_data, 32'h0000_8000);
        access(0, 2'b00, 0, 32'h11, 32'h0, 0, 0);
        check("lit_lb_signed", got_data, 32'hFFFF_FF80);
        access(0, 2'b00, 1, 32'h11, 32'h0, 0, 0);
        check("lit_lbu", got_data, 32'h0000_0080);

        access(0, 2'b01, 0, 32'h13, 32'h0, 0, 0);
        check("lit_half_misalign_fault", {31'd0, got_fault}, 32'd1);
        access(0, 2'b11, 0, 32'h10, 32'h0, 0, 0);
        check("lit_illegal_fault", {31'd0, got_fault}, 32'd1);
        access(1, 2'b01, 0, 32'h13, 32'hFFFF, 0, 0);
        access(1, 2'b10, 0, 32'h12, 32'hFFFF_FFFF, 0, 0);
        access(0, 2'b10, 0, 32'h10, 32'h0, 0, 0);
        check("lit_fault_no_write", got_data, 32'h0000_8000);

        access(1, 2'b10, 0, 32'(4*DEPTH + 8), 32'h1234_5678, 0, 0);
        access(0, 2'b10, 0, 32'h8, 32'h0, 0, 0);
        check("lit_wrap", got_data, 32'h1234_5678);

        access(1, 2'b10, 0, 32'h20, 32'h1122_3344, 0, 0);
        access(1, 2'b10, 0, 32'h20, 32'hAAAA_AAAA, 0, 1);
        access(0, 2'b10, 0, 32'h20, 32'h0, 0, 0);
        check("lit_abort_store", got_data, 32'h1122_3344);

        access(1, 2'b10, 0, 32'h40, 32'hCAFE_F00D, 1, 0);
        access(0, 2'b10, 0, 32'h40, 32'h0, 1, 0);
        check("lit_scramble", got_data, 32'hCAFE_F00D);

        access(1, 2'b10, 0, 32'h44, 32'h8001_7F02, 0, 0);
        access(0, 2'b01, 0, 32'h46, 32'h0, 0, 0);
        check("lit_lh_signed", got_data, 32'hFFFF_8001);
        access(0, 2'b01, 1, 32'h44, 32'h0, 0, 0);
        check("lit_lhu", got_data, 32'h0000_7F02);
        access(1, 2'b01, 0, 32'h46, 32'h0000_BEEF, 0, 0);
        access(0, 2'b10, 0, 32'h44, 32'h0, 0, 0);
        check("lit_half_merge", got_data, 32'hBEEF_7F02);

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
